// File: rtl/cheri_dec_ex_pipe.sv
// -----------------------------------------------------------------------------
// cheri_dec_ex_pipe
//
// Pipeline register between the CHERI decoder and the CHERI execute unit.
// Captures one decoded bundle and presents it to execute over valid/ready.
// A multicycle entry (SetBounds/CRRL/CRAM, CLC) is shown for MC_CYCLES beats
// before it retires. flush_i kills everything held and drops the bundle
// offered in the same cycle.
//
// Build option:
//   CHERI_DECPIPE_SKID_EN  defined   : one skid entry; in_ready_o is registered
//                          undefined : no skid; in_ready_o depends on ex_ready_i
//
// Parameters:
//   OPDW       width of the one-hot operator vector
//   MC_CYCLES  beats per multicycle entry (2..4)
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   flush_i                 kill held entries and the offered bundle
//   in_valid_i/in_ready_o   decoder-side handshake
//   in_operator_i, in_legal_i, in_multicycle_i, in_imm12_i, in_imm20_i,
//   in_imm21_i, in_cs2_i, in_pc_i            decoded bundle
//   ex_valid_o/ex_ready_i   execute-side beat handshake
//   ex_operator_o, ex_imm12_o, ex_imm20_o, ex_imm21_o, ex_cs2_o, ex_pc_o
//                           registered payload, zero while ex_valid_o=0
//   ex_illegal_o            entry decoded illegal (operator forced to zero)
//   ex_first_o, ex_last_o   beat 0 / final beat of the current entry
// -----------------------------------------------------------------------------
module cheri_dec_ex_pipe #(
  parameter int OPDW      = 16,
  parameter int MC_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,

  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [OPDW-1:0] in_operator_i,
  input  logic            in_legal_i,
  input  logic            in_multicycle_i,
  input  logic [11:0]     in_imm12_i,
  input  logic [19:0]     in_imm20_i,
  input  logic [20:0]     in_imm21_i,
  input  logic [4:0]      in_cs2_i,
  input  logic [31:0]     in_pc_i,

  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [OPDW-1:0] ex_operator_o,
  output logic [11:0]     ex_imm12_o,
  output logic [19:0]     ex_imm20_o,
  output logic [20:0]     ex_imm21_o,
  output logic [4:0]      ex_cs2_o,
  output logic [31:0]     ex_pc_o,
  output logic            ex_illegal_o,
  output logic            ex_first_o,
  output logic            ex_last_o
);

  localparam logic [1:0] LAST_BEAT = 2'(MC_CYCLES - 1);

  typedef struct packed {
    logic [OPDW-1:0] op;
    logic [11:0]     imm12;
    logic [19:0]     imm20;
    logic [20:0]     imm21;
    logic [4:0]      cs2;
    logic [31:0]     pc;
    logic            illegal;
    logic            mc;
  } entry_t;

  // Incoming bundle, normalised: an illegal bundle carries no operator and
  // is never multicycle, so execute sees exactly one beat to trap on.
  entry_t in_entry;
  always_comb begin
    in_entry.op      = in_legal_i ? in_operator_i : '0;
    in_entry.imm12   = in_imm12_i;
    in_entry.imm20   = in_imm20_i;
    in_entry.imm21   = in_imm21_i;
    in_entry.cs2     = in_cs2_i;
    in_entry.pc      = in_pc_i;
    in_entry.illegal = ~in_legal_i;
    in_entry.mc      = in_legal_i & in_multicycle_i;
  end

  // Output entry state
  logic   out_valid_reg, out_valid_next;
  entry_t out_entry_reg, out_entry_next;
  logic [1:0] beat_reg, beat_next;

  logic last_beat;
  logic beat_hs;
  logic retire;
  logic accept;

  assign last_beat = ~out_entry_reg.mc | (beat_reg == LAST_BEAT);
  assign beat_hs   = out_valid_reg & ex_ready_i;
  assign retire    = beat_hs & last_beat;
  assign accept    = in_valid_i & in_ready_o & ~flush_i;

`ifdef CHERI_DECPIPE_SKID_EN
  // Skid entry: only filled while the output entry is held, so
  // skid_valid_reg implies out_valid_reg.
  logic   skid_valid_reg, skid_valid_next;
  entry_t skid_entry_reg, skid_entry_next;

  // Ready depends only on registered state.
  assign in_ready_o = ~skid_valid_reg & ~rst_i;
`else
  // Ready looks through a retiring beat so single-beat entries stream at one
  // per cycle without a skid buffer.
  assign in_ready_o = ~rst_i & (~out_valid_reg | retire);
`endif

  always_comb begin
    out_valid_next  = out_valid_reg;
    out_entry_next  = out_entry_reg;
    beat_next       = beat_reg;
`ifdef CHERI_DECPIPE_SKID_EN
    skid_valid_next = skid_valid_reg;
    skid_entry_next = skid_entry_reg;
`endif
    if (flush_i) begin
      // Flush wins over any concurrent accept or handshake.
      out_valid_next  = 1'b0;
      beat_next       = 2'd0;
`ifdef CHERI_DECPIPE_SKID_EN
      skid_valid_next = 1'b0;
`endif
    end else begin
      if (beat_hs && !last_beat) begin
        beat_next = beat_reg + 2'd1;
      end
      if (retire) begin
        beat_next = 2'd0;
`ifdef CHERI_DECPIPE_SKID_EN
        // Skid holds the older bundle, so it goes first. in_ready_o is low
        // while skid is full, so no accept competes with this refill.
        if (skid_valid_reg) begin
          out_entry_next  = skid_entry_reg;
          skid_valid_next = 1'b0;
        end else if (accept) begin
          out_entry_next = in_entry;
        end else begin
          out_valid_next = 1'b0;
        end
`else
        if (accept) begin
          out_entry_next = in_entry;
        end else begin
          out_valid_next = 1'b0;
        end
`endif
      end else if (accept) begin
`ifdef CHERI_DECPIPE_SKID_EN
        if (out_valid_reg) begin
          skid_entry_next = in_entry;
          skid_valid_next = 1'b1;
        end else begin
          out_entry_next = in_entry;
          out_valid_next = 1'b1;
        end
`else
        out_entry_next = in_entry;
        out_valid_next = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_reg  <= 1'b0;
      out_entry_reg  <= '0;
      beat_reg       <= 2'd0;
`ifdef CHERI_DECPIPE_SKID_EN
      skid_valid_reg <= 1'b0;
      skid_entry_reg <= '0;
`endif
    end else begin
      out_valid_reg  <= out_valid_next;
      out_entry_reg  <= out_entry_next;
      beat_reg       <= beat_next;
`ifdef CHERI_DECPIPE_SKID_EN
      skid_valid_reg <= skid_valid_next;
      skid_entry_reg <= skid_entry_next;
`endif
    end
  end

  // Payload is masked while invalid so execute never sees stale state.
  assign ex_valid_o    = out_valid_reg;
  assign ex_operator_o = out_valid_reg ? out_entry_reg.op    : '0;
  assign ex_imm12_o    = out_valid_reg ? out_entry_reg.imm12 : '0;
  assign ex_imm20_o    = out_valid_reg ? out_entry_reg.imm20 : '0;
  assign ex_imm21_o    = out_valid_reg ? out_entry_reg.imm21 : '0;
  assign ex_cs2_o      = out_valid_reg ? out_entry_reg.cs2   : '0;
  assign ex_pc_o       = out_valid_reg ? out_entry_reg.pc    : '0;
  assign ex_illegal_o  = out_valid_reg & out_entry_reg.illegal;
  assign ex_first_o    = out_valid_reg & (beat_reg == 2'd0);
  assign ex_last_o     = out_valid_reg & last_beat;

endmodule

// File: tb/tb_cheri_dec_ex_pipe.sv
module tb_cheri_dec_ex_pipe;
  localparam int OPDW = 16;
  localparam int MC   = 2;
`ifdef CHERI_DECPIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [OPDW-1:0] in_op = '0;
  logic            in_legal = 1'b1;
  logic            in_mc = 1'b0;
  logic [11:0]     in_imm12 = '0;
  logic [19:0]     in_imm20 = '0;
  logic [20:0]     in_imm21 = '0;
  logic [4:0]      in_cs2 = '0;
  logic [31:0]     in_pc = '0;
  logic            ex_valid;
  logic            ex_ready = 1'b0;
  logic [OPDW-1:0] ex_op;
  logic [11:0]     ex_imm12;
  logic [19:0]     ex_imm20;
  logic [20:0]     ex_imm21;
  logic [4:0]      ex_cs2;
  logic [31:0]     ex_pc;
  logic            ex_illegal, ex_first, ex_last;

  always #5 clk = ~clk;

  cheri_dec_ex_pipe #(.OPDW(OPDW), .MC_CYCLES(MC)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_operator_i(in_op),
    .in_legal_i(in_legal), .in_multicycle_i(in_mc), .in_imm12_i(in_imm12),
    .in_imm20_i(in_imm20), .in_imm21_i(in_imm21), .in_cs2_i(in_cs2), .in_pc_i(in_pc),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready), .ex_operator_o(ex_op),
    .ex_imm12_o(ex_imm12), .ex_imm20_o(ex_imm20), .ex_imm21_o(ex_imm21),
    .ex_cs2_o(ex_cs2), .ex_pc_o(ex_pc), .ex_illegal_o(ex_illegal),
    .ex_first_o(ex_first), .ex_last_o(ex_last)
  );

  typedef struct packed {
    logic [OPDW-1:0] op;
    logic [11:0]     imm12;
    logic [19:0]     imm20;
    logic [20:0]     imm21;
    logic [4:0]      cs2;
    logic [31:0]     pc;
    logic            illegal;
    logic            mc;
  } ent_t;

  int   total = 0;
  int   bad = 0;
  // Reference model: ordered list of held entries plus beats already
  // consumed on the head entry.
  ent_t q[$];
  int   mbeat = 0;
  bit   acc_last = 1'b0;

  function automatic bit model_ready();
    if (rst) return 1'b0;
    if (SKID) return q.size() < 2;
    if (q.size() == 0) return 1'b1;
    return ex_ready && (!q[0].mc || mbeat == MC - 1);
  endfunction

  function automatic ent_t model_head();
    ent_t z;
    z = '0;
    if (q.size() > 0) z = q[0];
    return z;
  endfunction

  task automatic drive(input logic [31:0] pc, input logic [OPDW-1:0] op,
                       input logic legal, input logic mc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_op    = op;
    in_legal = legal;
    in_mc    = mc;
    in_imm12 = 12'($urandom);
    in_imm20 = 20'($urandom);
    in_imm21 = 21'($urandom);
    in_cs2   = 5'($urandom);
  endtask

  // Advance one clock and update the reference model.
  task automatic tick();
    ent_t e;
    bit   acc;
    acc       = in_valid && model_ready() && !flush && !rst;
    e.op      = in_legal ? in_op : '0;
    e.imm12   = in_imm12;
    e.imm20   = in_imm20;
    e.imm21   = in_imm21;
    e.cs2     = in_cs2;
    e.pc      = in_pc;
    e.illegal = !in_legal;
    e.mc      = in_legal && in_mc;
    @(posedge clk);
    #1;
    if (rst || flush) begin
      q.delete();
      mbeat = 0;
    end else begin
      if (q.size() > 0 && ex_ready) begin
        if (!q[0].mc || mbeat == MC - 1) begin
          $display("retire pc=%08h illegal=%0b beats=%0d", q[0].pc, q[0].illegal, mbeat + 1);
          void'(q.pop_front());
          mbeat = 0;
        end else begin
          mbeat++;
        end
      end
      if (acc) q.push_back(e);
    end
    acc_last = acc;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    flush    = 1'b0;
    ex_ready = 1'b1;
    repeat (MC + 3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (ex_valid !== 1'b0 || ex_first !== 1'b0 || ex_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid got v=%0b f=%0b l=%0b exp 0", ex_valid, ex_first, ex_last);
    end
    total++;
    if ({ex_op, ex_imm12, ex_imm20, ex_imm21, ex_cs2, ex_pc, ex_illegal} !== '0) begin
      bad++;
      $display("FAIL reset_payload got pc=%08h op=%h exp 0", ex_pc, ex_op);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready got %0b exp 0", in_ready);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got %0b exp 1", in_ready);
    end
    $display("reset checked");
  endtask

  task automatic test_back_to_back();
    ex_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(32'h100 + 32'(4 * i), OPDW'(1) << i, 1'b1, 1'b0);
      #1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_ready i=%0d got %0b exp 1", i, in_ready);
      end
      tick();
      total++;
      if (ex_valid !== 1'b1 || ex_pc !== 32'h100 + 32'(4 * i) || ex_first !== 1'b1 || ex_last !== 1'b1) begin
        bad++;
        $display("FAIL b2b_beat i=%0d got v=%0b pc=%08h f=%0b l=%0b exp v=1 pc=%08h f=1 l=1",
                 i, ex_valid, ex_pc, ex_first, ex_last, 32'h100 + 32'(4 * i));
      end
      $display("b2b beat pc=%08h", ex_pc);
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (ex_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_empty got %0b exp 0", ex_valid);
    end
  endtask

  task automatic test_multicycle();
    ex_ready = 1'b1;
    drive(32'h200, OPDW'(16'h0004), 1'b1, 1'b1);
    tick();
    total++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h200 || ex_first !== 1'b1 || ex_last !== 1'b0) begin
      bad++;
      $display("FAIL mc_beat0 got v=%0b pc=%08h f=%0b l=%0b exp v=1 pc=00000200 f=1 l=0",
               ex_valid, ex_pc, ex_first, ex_last);
    end
    drive(32'h204, OPDW'(16'h0010), 1'b1, 1'b0);
    tick();
    if (acc_last) in_valid = 1'b0;
    total++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h200 || ex_first !== 1'b0 || ex_last !== 1'b1) begin
      bad++;
      $display("FAIL mc_beat1 got v=%0b pc=%08h f=%0b l=%0b exp v=1 pc=00000200 f=0 l=1",
               ex_valid, ex_pc, ex_first, ex_last);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h204 || ex_first !== 1'b1 || ex_last !== 1'b1) begin
      bad++;
      $display("FAIL mc_next got v=%0b pc=%08h f=%0b l=%0b exp v=1 pc=00000204 f=1 l=1",
               ex_valid, ex_pc, ex_first, ex_last);
    end
    tick();
    total++;
    if (ex_valid !== 1'b0) begin
      bad++;
      $display("FAIL mc_empty got %0b exp 0", ex_valid);
    end
    $display("multicycle sequence checked");
  endtask

  task automatic test_backpressure();
    int            idx;
    logic [31:0]   got[$];
    idx = 0;
    ex_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 3) drive(32'h300 + 32'(4 * idx), OPDW'(2), 1'b1, 1'b0);
      else in_valid = 1'b0;
      tick();
      if (acc_last) idx++;
    end
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_ready_stalled got %0b exp 0", in_ready);
    end
    total++;
    if (idx !== (SKID ? 2 : 1)) begin
      bad++;
      $display("FAIL bp_held got %0d exp %0d", idx, SKID ? 2 : 1);
    end
    ex_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== (SKID ? 1'b0 : 1'b1)) begin
      bad++;
      $display("FAIL bp_ready_release got %0b exp %0b", in_ready, SKID ? 1'b0 : 1'b1);
    end
    for (int c = 0; c < 12 && got.size() < 3; c++) begin
      if (idx < 3) drive(32'h300 + 32'(4 * idx), OPDW'(2), 1'b1, 1'b0);
      else in_valid = 1'b0;
      if (ex_valid && ex_last) got.push_back(ex_pc);
      tick();
      if (acc_last) idx++;
    end
    in_valid = 1'b0;
    total++;
    if (got.size() !== 3) begin
      bad++;
      $display("FAIL bp_count got %0d exp 3", got.size());
    end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      total++;
      if (got[i] !== 32'h300 + 32'(4 * i)) begin
        bad++;
        $display("FAIL bp_order i=%0d got %08h exp %08h", i, got[i], 32'h300 + 32'(4 * i));
      end
      $display("bp delivered pc=%08h", got[i]);
    end
    drain();
  endtask

  task automatic test_illegal();
    ex_ready = 1'b1;
    drive(32'h600, OPDW'(16'h0040), 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    total++;
    if (ex_valid !== 1'b1 || ex_illegal !== 1'b1 || ex_op !== '0 || ex_first !== 1'b1 || ex_last !== 1'b1) begin
      bad++;
      $display("FAIL illegal_beat got v=%0b ill=%0b op=%h f=%0b l=%0b exp v=1 ill=1 op=0 f=1 l=1",
               ex_valid, ex_illegal, ex_op, ex_first, ex_last);
    end
    tick();
    total++;
    if (ex_valid !== 1'b0) begin
      bad++;
      $display("FAIL illegal_single got %0b exp 0", ex_valid);
    end
    $display("illegal entry checked");
  endtask

  task automatic test_flush();
    ex_ready = 1'b0;
    drive(32'h400, OPDW'(16'h0004), 1'b1, 1'b1);
    tick();
    drive(32'h404, OPDW'(1), 1'b1, 1'b0);
    tick();
    drive(32'h408, OPDW'(1), 1'b1, 1'b0);
    flush = 1'b1;
    ex_ready = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    total++;
    if (ex_valid !== 1'b0 || ex_first !== 1'b0 || ex_last !== 1'b0 || ex_pc !== 32'h0) begin
      bad++;
      $display("FAIL flush_out got v=%0b f=%0b l=%0b pc=%08h exp all 0", ex_valid, ex_first, ex_last, ex_pc);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_ready got %0b exp 1", in_ready);
    end
    tick();
    total++;
    if (ex_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_dropped got %0b pc=%08h exp 0", ex_valid, ex_pc);
    end
    drive(32'h40C, OPDW'(16'h0004), 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    total++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h40C || ex_first !== 1'b1 || ex_last !== 1'b0) begin
      bad++;
      $display("FAIL flush_restart got v=%0b pc=%08h f=%0b l=%0b exp v=1 pc=0000040c f=1 l=0",
               ex_valid, ex_pc, ex_first, ex_last);
    end
    $display("flush checked");
    drain();
  endtask

  task automatic test_reset_mid();
    ex_ready = 1'b0;
    drive(32'h500, OPDW'(8), 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    total++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h500) begin
      bad++;
      $display("FAIL rmid_held got v=%0b pc=%08h exp v=1 pc=00000500", ex_valid, ex_pc);
    end
    rst = 1'b1;
    tick();
    total++;
    if (ex_valid !== 1'b0 || {ex_op, ex_imm12, ex_imm20, ex_imm21, ex_cs2, ex_pc, ex_illegal} !== '0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rmid_reset got v=%0b pc=%08h rdy=%0b exp v=0 pc=0 rdy=0", ex_valid, ex_pc, in_ready);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rmid_ready got %0b exp 1", in_ready);
    end
    drive(32'h504, OPDW'(8), 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    total++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h504 || ex_first !== 1'b1) begin
      bad++;
      $display("FAIL rmid_first got v=%0b pc=%08h f=%0b exp v=1 pc=00000504 f=1", ex_valid, ex_pc, ex_first);
    end
    $display("reset mid-operation checked");
    drain();
  endtask

  task automatic test_random();
    ent_t e;
    bit   ev;
    for (int c = 0; c < 400; c++) begin
      drive(32'($urandom), OPDW'(1) << $urandom_range(0, OPDW - 1), 1'b1, 1'b0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_legal = ($urandom_range(0, 7) != 0);
      in_mc    = ($urandom_range(0, 2) == 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 24) == 0);
      #1;
      total++;
      if (in_ready !== model_ready()) begin
        bad++;
        $display("FAIL rand_ready cyc=%0d got %0b exp %0b", c, in_ready, model_ready());
      end
      tick();
      e  = model_head();
      ev = q.size() > 0;
      total++;
      if (ex_valid !== ev) begin
        bad++;
        $display("FAIL rand_valid cyc=%0d got %0b exp %0b", c, ex_valid, ev);
      end
      total++;
      if ({ex_op, ex_imm12, ex_imm20, ex_imm21, ex_cs2, ex_pc, ex_illegal} !==
          {e.op, e.imm12, e.imm20, e.imm21, e.cs2, e.pc, e.illegal}) begin
        bad++;
        $display("FAIL rand_payload cyc=%0d got pc=%08h op=%h ill=%0b exp pc=%08h op=%h ill=%0b",
                 c, ex_pc, ex_op, ex_illegal, e.pc, e.op, e.illegal);
      end
      total++;
      if (ex_first !== (ev && mbeat == 0) || ex_last !== (ev && (!e.mc || mbeat == MC - 1))) begin
        bad++;
        $display("FAIL rand_beat cyc=%0d got f=%0b l=%0b exp f=%0b l=%0b", c, ex_first, ex_last,
                 ev && mbeat == 0, ev && (!e.mc || mbeat == MC - 1));
      end
    end
    flush = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_multicycle();
    test_backpressure();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cheri_dec_ex_pipe.md
# cheri_dec_ex_pipe

Pipeline register stage between the CHERI instruction decoder and the CHERI execute unit.
- Captures the decoded CHERI bundle: one-hot operator vector, immediates, CSR index, PC, multicycle flag, legality.
- Presents it to execute over a valid/ready handshake.
- Sequences multicycle operations (two-cycle SetBounds/CRRL/CRAM, non-pipelined CLC) by repeating the entry for a fixed number of beats.
- Provides flush for branch/exception kill and, optionally, a skid entry that keeps the upstream ready fully registered.

## Interface
- MC_CYCLES, 2: beats a multicycle entry occupies at the output; legal range 2..4.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  kill all held entries and drop any entry offered this cycle.
- in_valid_i  in  1  decoded bundle valid.
- in_ready_o  out  1  stage can accept a bundle.
- in_operator_i  in  OPDW  one-hot CHERI operator vector (cheri_pkg).
- in_legal_i  in  1  bundle decoded as a legal CHERI instruction.
- in_multicycle_i  in  1  operation needs MC_CYCLES beats.
- in_imm12_i  in  12; in_imm20_i  in  20; in_imm21_i  in  21  immediates.
- in_cs2_i  in  5  SCR index for CSpecialRW.
- in_pc_i  in  32  instruction PC.
- ex_valid_o  out  1  beat valid to execute.
- ex_ready_i  in  1  execute consumes the current beat.
- ex_operator_o  out  OPDW; ex_imm12_o, ex_imm20_o, ex_imm21_o, ex_cs2_o, ex_pc_o  out  as inputs  registered payload.
- ex_illegal_o  out  1  entry was illegal; operator forced to zero.
- ex_first_o  out  1  current beat is beat 0 of the entry.
- ex_last_o  out  1  current beat is the final beat; entry retires on handshake.

## Operation
- Accept: `in_valid_i & in_ready_o & ~flush_i`.
- Beat handshake: `ex_valid_o & ex_ready_i`. Retire: beat handshake while `ex_last_o`=1.
- Output entry registers: out_valid, payload, mc flag, beat counter `beat` (2 bits).
- Skid entry registers: skid_valid, skid payload.
- Illegal bundle (`in_legal_i`=0):
  - Stored with operator zeroed and illegal=1.
  - mc is forced to 0, so the entry is a single beat.
- `ex_first_o` = (beat==0).
- `ex_last_o` = ~mc | (beat==MC_CYCLES-1).
- Beat handshake that is not last: beat increments, and the payload holds.
- Retire: beat resets to 0, and the output loads from skid if skid_valid, else from the input if an accept occurs, else out_valid clears.
- Accept when out_valid=0 or the entry retires this cycle: load the output directly.
- Accept otherwise: load skid. Only legal when skid is empty, which in_ready_o guarantees.
- Payload outputs are driven to zero whenever ex_valid_o=0. `ex_first_o`/`ex_last_o` are 0 when invalid.
- Flush (flush_i=1) for one cycle:
  - out_valid, skid_valid and beat clear next cycle.
  - Any concurrent accept or handshake is discarded; flush has priority.
- Reset, next edge with rst_i=1:
  - ex_valid_o=0, all payload outputs 0, ex_illegal_o=0, beat=0, skid empty.
  - in_ready_o=0 while rst_i is high.

## Timing
- Latency: input accepted at edge N appears on ex_valid_o in cycle N+1. No combinational path from in_* to ex_*.
- Single-beat entries sustain 1 per cycle when ex_ready_i stays high.
- A multicycle entry occupies the output for at least MC_CYCLES cycles.
- ex_valid_o may not drop, and the payload may not change, between handshakes of a held beat, except under flush or reset.
- A stalled beat (ex_ready_i=0) holds beat and payload indefinitely.

## Configuration
- Macro: `CHERI_DECPIPE_SKID_EN`.
- Defined:
  - Skid entry present.
  - in_ready_o = ~skid_valid & ~rst_i, purely registered.
  - One extra bundle is absorbed while the output stalls.
- Undefined:
  - No skid storage.
  - in_ready_o = ~rst_i & (~out_valid | retire). This is a combinational path from ex_ready_i.
  - Accepts always load the output register.
- Functional ordering is identical in both builds; only buffering depth and ready timing differ.

## Test plan
- Back-to-back single-beat: 4 legal bundles, PC 0x100..0x10C, ex_ready_i=1 → ex_valid_o high cycles 1..4, ex_pc_o 0x100..0x10C in order, first=last=1 each beat.
- Multicycle: MC_CYCLES=2, CSetBounds with in_multicycle_i=1 at PC 0x200, followed by a single-beat op at 0x204 → 0x200 shown for 2 beats (first=1,last=0 then first=0,last=1), then 0x204 the next cycle.
- Backpressure:
  - ex_ready_i=0 for 5 cycles while 3 bundles are offered.
  - With macro: 2 are held and in_ready_o drops after the second; release delivers them in order with no loss or duplication.
  - Without macro: 1 is held and in_ready_o tracks ex_ready_i.
- Illegal: in_legal_i=0, operator=0x40, in_multicycle_i=1 → one beat, ex_illegal_o=1, ex_operator_o=0, last=1.
- Flush mid-multicycle: flush_i during beat 0 of a multicycle entry with skid occupied and in_valid_i=1 → next cycle ex_valid_o=0, skid empty, offered bundle dropped, beat=0.
- Reset mid-operation: rst_i asserted with a stalled entry → next cycle ex_valid_o=0, all payload 0, in_ready_o=0. After deassertion, in_ready_o=1 and the first new bundle appears with first=1.
